audio_framer: RTL and testbench
===============================

# audio_framer

- Framing stage of the MFCC pipeline: sits directly downstream of pre-emphasis and upstream of windowing/Goertzel.
- Accepts a pre-emphasized 16-bit sample stream and stores it in a circular buffer.
- Emits overlapping frames of `frame_size` samples, advancing by `frame_size - frame_overlap` samples per frame.
- Output is a valid/ready sample stream with first/last frame markers.

## Interface

Parameters:

- `DATA_W`, 16: sample width.
- `MAX_FRAME`, 256: buffer depth. Must be a power of two.
- `ADDR_W`, 8: log2(`MAX_FRAME`).

Ports:

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `enable`  in  1  run enable; low flushes the block to IDLE.
- `frame_size`  in  ADDR_W+1  samples per frame; valid range 1..MAX_FRAME.
- `frame_overlap`  in  ADDR_W+1  samples shared by consecutive frames; must be < `frame_size`.
- `sample_in`  in  DATA_W  pre-emphasized sample.
- `sample_valid`  in  1  `sample_in` is valid.
- `sample_ready`  out  1  block accepts `sample_in` this cycle.
- `frame_out`  out  DATA_W  frame sample.
- `frame_valid`  out  1  `frame_out` is valid.
- `frame_ready`  in  1  consumer accepts `frame_out`.
- `frame_first`  out  1  `frame_out` is sample 0 of a frame.
- `frame_last`  out  1  `frame_out` is sample `frame_size-1` of a frame.
- `frame_index`  out  16  frame number since leaving IDLE; wraps at 65535.
- `cfg_err`  out  1  latched configuration is invalid.
- `overflow`  out  1  sticky dropped-sample flag; see Configuration.

## Operation

- States: IDLE, FILL, EMIT.
- **IDLE**
  - Entered on reset or when `enable`=0.
  - On `enable`=1, latch `frame_size` and `frame_overlap`, then compute hop = size − overlap.
  - Invalid config (size=0, size>MAX_FRAME, or overlap≥size): set `cfg_err`=1 and stay in IDLE.
  - Valid config: clear `cfg_err`, set need=size, wr_ptr=0, start=0, `frame_index`=0, go to FILL.
  - The latched config does not change until the block returns to IDLE.
- **FILL**
  - `sample_ready`=1.
  - Each handshake (`sample_valid`&`sample_ready`) writes buf[wr_ptr], increments wr_ptr mod MAX_FRAME, decrements need.
  - When need reaches 0 on a handshake, go to EMIT.
- **EMIT**
  - `sample_ready`=0; input samples are stalled, not dropped, unless the overflow feature treats them as dropped.
  - Read buf[(start+k) mod MAX_FRAME] for k = 0..size-1, in order.
  - Memory read is synchronous; the output register holds one sample.
  - Reads are issued so that a continuously high `frame_ready` gives one sample per cycle.
  - `frame_first`=1 with k=0; `frame_last`=1 with k=size-1.
  - When the `frame_last` beat is accepted: start += hop mod MAX_FRAME, need=hop, `frame_index`+1, go to FILL.
- Overwrite safety: the hop new samples written in FILL overwrite exactly the hop oldest samples, which no later frame uses.
- Pointer wrap: `wr_ptr` and `start` wrap modulo MAX_FRAME with no gap or duplicate.
- `enable` low in any state: next cycle the block is in IDLE, `frame_valid`=0, any partial frame is discarded, and `frame_index` is held.

## Timing

- Reset values: `sample_ready`=0, `frame_valid`=0, `frame_out`=0, `frame_first`=0, `frame_last`=0, `frame_index`=0, `cfg_err`=0, `overflow`=0; state=IDLE.
- IDLE→FILL takes 1 cycle after `enable` rises, so `sample_ready` goes high on the 2nd edge.
- `frame_valid` for k=0 rises 2 cycles after the handshake that completes the fill (1 cycle state change, 1 cycle RAM read).
- `frame_out` and the marker outputs hold stable while `frame_valid`=1 and `frame_ready`=0.
- `frame_valid` never drops without a handshake, except on `enable`=0 or reset.
- After the last beat is accepted, `sample_ready` returns high the next cycle.
- frame_size=1, overlap=0: every input sample produces a 1-sample frame with `frame_first`=`frame_last`=1.

## Configuration

- `FRAMER_OVERFLOW_EN` defined:
  - `overflow` sets when `sample_valid`=1 and `sample_ready`=0 in state EMIT; that sample is counted as dropped.
  - Clears only on reset or IDLE entry.
- Not defined: `overflow` is tied to 0 and no detection logic exists.

## Test plan

- size=8, overlap=4, samples 1..16 fed back-to-back, `frame_ready`=1 → frames [1..8], [5..12], [9..16]; `frame_index` 0, 1, 2; first/last markers on beats 0 and 7.
- Same stream, `frame_ready` toggled 1/0 each cycle → identical data; `frame_out` stable during every ready=0 cycle.
- size=256, overlap=128, samples 0..767 → frame 2 = samples 256..511 read across the buffer wrap (start=0, ptr wraps); frame 4 = 512..767.
- size=0, then size=300, then overlap=8 with size=8 → each gives `cfg_err`=1, `sample_ready` held 0, no `frame_valid`.
- `enable` dropped mid-EMIT at beat 3 of frame 1 → next cycle `frame_valid`=0; on re-enable, the first frame is built from fresh samples and `frame_index`=0.
- With `FRAMER_OVERFLOW_EN`, `sample_valid` held 1 during EMIT → `overflow`=1 stays set until `enable` is cycled. Without the macro → `overflow` stays 0.

Source files
------------

// File: rtl/audio_framer.sv
// audio_framer -- framing stage of the MFCC pipeline.
//
// Buffers a pre-emphasized sample stream in a circular RAM and replays it as
// overlapping frames of frame_size samples. Consecutive frames start
// frame_size - frame_overlap samples apart.
//
// Optional feature: define FRAMER_OVERFLOW_EN to enable the sticky overflow
// flag. When it is not defined, overflow is tied low and has no logic.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   enable            run enable; low returns the block to IDLE next cycle
//   frame_size        samples per frame, 1..MAX_FRAME (latched in IDLE)
//   frame_overlap     samples shared by consecutive frames, < frame_size
//   sample_in/valid   input stream; sample_ready is high only in FILL
//   frame_out/valid   output stream; frame_ready is the consumer's accept
//   frame_first/last  beat is sample 0 / sample frame_size-1 of a frame
//   frame_index       frame number since leaving IDLE, wraps at 16 bits
//   cfg_err           latched configuration is invalid
//   overflow          sticky: a sample was offered during EMIT
//   dbg_state         current FSM state (0 IDLE, 1 FILL, 2 EMIT)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its data stable until the
// transfer; valid is withdrawn without a transfer only on enable=0 or reset.
module audio_framer #(
    parameter int DATA_W    = 16,
    parameter int MAX_FRAME = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [ADDR_W:0]   frame_size,
    input  logic [ADDR_W:0]   frame_overlap,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic [DATA_W-1:0] frame_out,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              frame_first,
    output logic              frame_last,
    output logic [15:0]       frame_index,
    output logic              cfg_err,
    output logic              overflow,
    output logic [1:0]        dbg_state
);

    localparam int CW = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DATA_W-1:0] r_mem [MAX_FRAME];

    logic [CW-1:0]     r_size;
    logic [CW-1:0]     r_hop;
    logic [CW-1:0]     r_need;
    logic [CW-1:0]     r_issue_k;   // number of reads issued in this frame
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_start;
    logic [15:0]       r_frame_index;
    logic              r_cfg_err;
    logic [DATA_W-1:0] r_frame_out;
    logic              r_valid;
    logic              r_first;
    logic              r_last;

    logic              w_cfg_ok;
    logic              w_fill_hs;
    logic              w_rd_en;
    logic              w_last_acc;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_cfg_ok = (frame_size != '0)
                   && (frame_size <= CW'(MAX_FRAME))
                   && (frame_overlap < frame_size);

    assign sample_ready = (r_state == S_FILL) && enable;
    assign w_fill_hs    = sample_ready && sample_valid;

    // The RAM read register doubles as the output register, so a new read is
    // issued only when that register is empty or being drained this cycle.
    assign w_rd_en    = enable && (r_state == S_EMIT) && (r_issue_k < r_size)
                     && (!r_valid || frame_ready);
    assign w_rd_addr  = r_start + r_issue_k[ADDR_W-1:0];
    assign w_last_acc = (r_state == S_EMIT) && r_valid && r_last && frame_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (enable && w_cfg_ok) w_next = S_FILL;
            S_FILL: if (w_fill_hs && (r_need == CW'(1))) w_next = S_EMIT;
            S_EMIT: if (w_last_acc) w_next = S_FILL;
            default: w_next = S_IDLE;
        endcase
        if (!enable) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (w_fill_hs) r_mem[r_wr_ptr] <= sample_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_out <= '0;
        end else if (w_rd_en) begin
            r_frame_out <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_size        <= '0;
            r_hop         <= '0;
            r_need        <= '0;
            r_issue_k     <= '0;
            r_wr_ptr      <= '0;
            r_start       <= '0;
            r_frame_index <= '0;
            r_cfg_err     <= 1'b0;
            r_valid       <= 1'b0;
            r_first       <= 1'b0;
            r_last        <= 1'b0;
        end else if (!enable) begin
            // Discard any partial frame; frame_index and cfg_err are held.
            r_issue_k <= '0;
            r_valid   <= 1'b0;
            r_first   <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_size <= frame_size;
                    r_hop  <= frame_size - frame_overlap;
                    if (w_cfg_ok) begin
                        r_cfg_err     <= 1'b0;
                        r_need        <= frame_size;
                        r_wr_ptr      <= '0;
                        r_start       <= '0;
                        r_frame_index <= '0;
                        r_issue_k     <= '0;
                    end else begin
                        r_cfg_err <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (w_fill_hs) begin
                        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                        r_need   <= r_need - CW'(1);
                    end
                end
                S_EMIT: begin
                    if (w_rd_en) begin
                        r_issue_k <= r_issue_k + CW'(1);
                        r_valid   <= 1'b1;
                        r_first   <= (r_issue_k == '0);
                        r_last    <= (r_issue_k == r_size - CW'(1));
                    end else if (frame_ready) begin
                        r_valid <= 1'b0;
                    end
                    if (w_last_acc) begin
                        // Truncation to ADDR_W bits gives the modulo wrap;
                        // hop = MAX_FRAME correctly adds zero.
                        r_start       <= r_start + r_hop[ADDR_W-1:0];
                        r_need        <= r_hop;
                        r_issue_k     <= '0;
                        r_frame_index <= r_frame_index + 16'd1;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FRAMER_OVERFLOW_EN
    logic r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (!enable || (r_state == S_IDLE)) begin
            r_overflow <= 1'b0;
        end else if ((r_state == S_EMIT) && sample_valid) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

    assign frame_out   = r_frame_out;
    assign frame_valid = r_valid;
    assign frame_first = r_first;
    assign frame_last  = r_last;
    assign frame_index = r_frame_index;
    assign cfg_err     = r_cfg_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_audio_framer.sv
// Testbench for audio_framer: directed frame streams with a scoreboard of
// expected output beats checked by an independent monitor.
module tb_audio_framer;

    typedef struct packed {
        logic [15:0] data;
        logic        first;
        logic        last;
        logic [15:0] idx;
    } beat_t;

`ifdef FRAMER_OVERFLOW_EN
    localparam int OVF_EXP = 1;
`else
    localparam int OVF_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [8:0]  frame_size = '0;
    logic [8:0]  frame_overlap = '0;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [15:0] frame_out;
    logic        frame_valid;
    logic        frame_ready = 1'b1;
    logic        frame_first;
    logic        frame_last;
    logic [15:0] frame_index;
    logic        cfg_err;
    logic        overflow;
    logic [1:0]  dbg_state;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    bit    ready_toggle = 1'b0;

    audio_framer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .frame_size   (frame_size),
        .frame_overlap(frame_overlap),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .frame_out    (frame_out),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_first  (frame_first),
        .frame_last   (frame_last),
        .frame_index  (frame_index),
        .cfg_err      (cfg_err),
        .overflow     (overflow),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset / consumer ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (ready_toggle) frame_ready = ~frame_ready;
        else              frame_ready = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d beats still expected", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_beat(input int data, input bit first, input bit last, input int idx);
        beat_t b;
        b.data  = 16'(data);
        b.first = first;
        b.last  = last;
        b.idx   = 16'(idx);
        exp_q.push_back(b);
    endtask

    // Every complete frame contained in n samples starting at value base.
    task automatic push_frames(input int size, input int overlap, input int base, input int n);
        int hop;
        int f;
        hop = size - overlap;
        f = 0;
        for (int s = 0; s + size <= n; s += hop) begin
            for (int k = 0; k < size; k++)
                push_beat(base + s + k, k == 0, k == size - 1, f);
            f++;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic feed(input int base, input int n);
        bit done;
        for (int i = 0; i < n; i++) begin
            sample_in = 16'(base + i);
            sample_valid = 1'b1;
            done = 1'b0;
            for (int t = 0; t < 3000 && !done; t++) begin
                @(negedge clk);
                if (sample_ready) begin
                    @(posedge clk);
                    #1;
                    done = 1'b1;
                end
            end
            if (!done) begin
                n_checks++;
                n_fail++;
                $display("FAIL feed_timeout: sample %0d not accepted, expected acceptance", base + i);
                sample_valid = 1'b0;
                return;
            end
        end
        sample_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 4000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk({name, "_drain_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Restart with a new configuration; for a valid one also checks the
    // one-cycle IDLE->FILL latency of sample_ready.
    task automatic start_cfg(input int size, input int overlap, input bit ok);
        enable = 1'b0;
        cycles(2);
        frame_size = 9'(size);
        frame_overlap = 9'(overlap);
        enable = 1'b1;
        if (ok) begin
            @(negedge clk);
            chk("ready_before_fill", int'(sample_ready), 0);
            @(negedge clk);
            chk("ready_in_fill", int'(sample_ready), 1);
            chk("cfg_err_clear", int'(cfg_err), 0);
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    beat_t held;
    bit    hold_chk = 1'b0;

    always @(negedge clk) begin
        beat_t got;
        beat_t exp;
        got.data  = frame_out;
        got.first = frame_first;
        got.last  = frame_last;
        got.idx   = frame_index;
        if (hold_chk && enable) begin
            n_checks++;
            if (!frame_valid || got !== held) begin
                n_fail++;
                $display("FAIL stall_hold: valid=%0b data=%0d f=%0b l=%0b idx=%0d, expected valid=1 data=%0d f=%0b l=%0b idx=%0d",
                         frame_valid, got.data, got.first, got.last, got.idx,
                         held.data, held.first, held.last, held.idx);
            end
        end
        if (frame_valid && frame_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: data=%0d f=%0b l=%0b idx=%0d, expected no beat",
                         got.data, got.first, got.last, got.idx);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL frame_beat: data=%0d f=%0b l=%0b idx=%0d, expected data=%0d f=%0b l=%0b idx=%0d",
                             got.data, got.first, got.last, got.idx,
                             exp.data, exp.first, exp.last, exp.idx);
                end
            end
        end
        hold_chk = frame_valid && !frame_ready && enable;
        held = got;
    end

    // ---------------- test sequence ----------------
    initial begin
        cycles(3);
        @(negedge clk);
        chk("rst_sample_ready", int'(sample_ready), 0);
        chk("rst_frame_valid", int'(frame_valid), 0);
        chk("rst_frame_out", int'(frame_out), 0);
        chk("rst_first_last", int'({frame_first, frame_last}), 0);
        chk("rst_frame_index", int'(frame_index), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_state", int'(dbg_state), 0);
        rst_n = 1'b1;
        cycles(2);

        // size 8 / overlap 4, consumer always ready
        start_cfg(8, 4, 1'b1);
        push_frames(8, 4, 1, 16);
        feed(1, 16);
        drain("basic");

        // same stream, consumer toggling ready every cycle
        ready_toggle = 1'b1;
        start_cfg(8, 4, 1'b1);
        push_frames(8, 4, 1, 16);
        feed(1, 16);
        drain("toggle");
        ready_toggle = 1'b0;

        // full-depth frames with buffer wrap
        start_cfg(256, 128, 1'b1);
        push_frames(256, 128, 0, 768);
        feed(0, 768);
        drain("wrap");

        // single-sample frames
        start_cfg(1, 0, 1'b1);
        push_frames(1, 0, 7, 3);
        feed(7, 3);
        drain("size1");

        // invalid configurations
        for (int c = 0; c < 3; c++) begin
            int sz;
            int ov;
            sz = (c == 0) ? 0 : (c == 1) ? 300 : 8;
            ov = (c == 2) ? 8 : 0;
            start_cfg(sz, ov, 1'b0);
            sample_in = 16'hBEEF;
            sample_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("bad_cfg_ready", int'(sample_ready), 0);
                chk("bad_cfg_valid", int'(frame_valid), 0);
            end
            chk("bad_cfg_err", int'(cfg_err), 1);
            chk("bad_cfg_state", int'(dbg_state), 0);
            @(posedge clk);
            #1;
            sample_valid = 1'b0;
        end

        // enable dropped during frame 1, then a fresh start
        start_cfg(8, 4, 1'b1);
        push_frames(8, 4, 1, 8);
        for (int k = 0; k < 3; k++) push_beat(5 + k, k == 0, 1'b0, 1);
        feed(1, 12);
        begin
            int t;
            t = 0;
            while (exp_q.size() != 0 && t < 200) begin
                @(negedge clk);
                #1;
                t++;
            end
            chk("abort_reached_beat3", exp_q.size(), 0);
        end
        enable = 1'b0;
        @(negedge clk);
        chk("abort_valid_low", int'(frame_valid), 0);
        chk("abort_state_idle", int'(dbg_state), 0);
        chk("abort_index_held", int'(frame_index), 1);
        start_cfg(8, 4, 1'b1);
        chk("restart_index", int'(frame_index), 0);
        push_frames(8, 4, 101, 8);
        feed(101, 8);
        drain("restart");

        // overflow: samples offered while a frame is being emitted
        start_cfg(4, 0, 1'b1);
        chk("ovf_start_clear", int'(overflow), 0);
        push_frames(4, 0, 200, 4);
        feed(200, 4);
        sample_in = 16'h1234;
        sample_valid = 1'b1;
        cycles(2);
        sample_valid = 1'b0;
        drain("ovf");
        @(negedge clk);
        chk("ovf_sticky", int'(overflow), OVF_EXP);
        start_cfg(4, 0, 1'b1);
        chk("ovf_cleared_by_idle", int'(overflow), 0);

        enable = 1'b0;
        cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
